// File: rtl/tmds_decoder.sv
// tmds_decoder: single TMDS channel receive decoder.
// Aligns raw 10-bit deserializer words to the TMDS word boundary by hunting
// for runs of control tokens across the ten possible bit offsets, then
// decodes aligned words into pixel data, data enable and two control bits.
// Optional build macro TMDS_DECODER_STATS_EN adds the realign_cnt port, a
// saturating count of lock losses.
`timescale 1ns/1ps
module tmds_decoder #(
  parameter int CTRL_RUN      = 8,
  parameter int SEARCH_CYCLES = 1024,
  parameter int LOCK_TIMEOUT  = 1048576
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] tmds_in,
  output logic [7:0] data_out,
  output logic       data_en,
  output logic       ctrl0_out,
  output logic       ctrl1_out,
  output logic       aligned,
  output logic [3:0] phase
`ifdef TMDS_DECODER_STATS_EN
  ,
  output logic [7:0] realign_cnt
`endif
);

  localparam int RUN_W   = $clog2(CTRL_RUN + 1);
  localparam int DWELL_W = $clog2(SEARCH_CYCLES + 1);
  localparam int TO_W    = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic {
    ST_SEARCH,
    ST_LOCKED
  } state_t;

  state_t             state;
  logic [9:0]         cur_q;
  logic [9:0]         prev_q;
  logic [9:0]         w;
  logic               is_tok;
  logic [1:0]         tok_c;
  logic [7:0]         d;
  logic [7:0]         dec;
  logic [1:0]         ctrl_hold;
  logic [RUN_W-1:0]   run_cnt;
  logic [DWELL_W-1:0] dwell_cnt;
  logic [TO_W-1:0]    to_cnt;
  logic               run_full;
  logic               dwell_end;
  logic               to_end;
  logic               drop_lock;
  logic               slip;
  logic [3:0]         phase_inc;

  assign aligned = (state == ST_LOCKED);

  // Two-word history so any 10-bit window straddling a word boundary is visible
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q  <= '0;
      prev_q <= '0;
    end else begin
      cur_q  <= tmds_in;
      prev_q <= cur_q;
    end
  end

  // Barrel shifter, token detect and TMDS data decode on the selected window
  always_comb begin
    w      = 10'({cur_q, prev_q} >> phase);
    is_tok = 1'b1;
    tok_c  = 2'b00;
    case (w)
      10'h354: tok_c = 2'b00;
      10'h0AB: tok_c = 2'b01;
      10'h154: tok_c = 2'b10;
      10'h2AB: tok_c = 2'b11;
      default: is_tok = 1'b0;
    endcase
    d      = w[9] ? ~w[7:0] : w[7:0];
    dec    = '0;
    dec[0] = d[0];
    for (int unsigned i = 1; i < 8; i++) begin
      dec[i] = w[8] ? (d[i] ^ d[i-1]) : ~(d[i] ^ d[i-1]);
    end
  end

  // Lock/slip decisions; a completed run always takes priority over a slip
  always_comb begin
    run_full  = (run_cnt == RUN_W'(CTRL_RUN));
    dwell_end = (dwell_cnt == DWELL_W'(SEARCH_CYCLES - 1));
    to_end    = (to_cnt == TO_W'(LOCK_TIMEOUT - 1));
    drop_lock = (state == ST_LOCKED) && !run_full && to_end;
    slip      = ((state == ST_SEARCH) && !run_full && dwell_end) || drop_lock;
    phase_inc = (phase == 4'd9) ? 4'd0 : 4'(phase + 4'd1);
  end

  // Consecutive-token run counter, restarted by data words and offset slips
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt <= '0;
    end else if (slip || !is_tok) begin
      run_cnt <= '0;
    end else if (!run_full) begin
      run_cnt <= run_cnt + 1'b1;
    end
  end

  // Alignment FSM: dwell on each offset while searching, watchdog while locked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_SEARCH;
      phase     <= '0;
      dwell_cnt <= '0;
      to_cnt    <= '0;
    end else begin
      case (state)
        ST_SEARCH: begin
          if (run_full) begin
            state     <= ST_LOCKED;
            dwell_cnt <= '0;
            to_cnt    <= '0;
          end else if (dwell_end) begin
            phase     <= phase_inc;
            dwell_cnt <= '0;
          end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
          end
        end
        ST_LOCKED: begin
          if (run_full) begin
            to_cnt <= '0;
          end else if (to_end) begin
            state     <= ST_SEARCH;
            phase     <= phase_inc;
            dwell_cnt <= '0;
            to_cnt    <= '0;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        default: state <= ST_SEARCH;
      endcase
    end
  end

  // Registered decoder outputs, held at zero until the boundary is locked
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_hold <= '0;
      data_out  <= '0;
      data_en   <= 1'b0;
      ctrl0_out <= 1'b0;
      ctrl1_out <= 1'b0;
    end else begin
      if (is_tok) begin
        ctrl_hold <= tok_c;
      end
      if (!aligned) begin
        data_out  <= '0;
        data_en   <= 1'b0;
        ctrl0_out <= 1'b0;
        ctrl1_out <= 1'b0;
      end else if (is_tok) begin
        data_out  <= '0;
        data_en   <= 1'b0;
        ctrl0_out <= tok_c[0];
        ctrl1_out <= tok_c[1];
      end else begin
        data_out  <= dec;
        data_en   <= 1'b1;
        ctrl0_out <= ctrl_hold[0];
        ctrl1_out <= ctrl_hold[1];
      end
    end
  end

`ifdef TMDS_DECODER_STATS_EN
  // Saturating count of lock losses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      realign_cnt <= '0;
    end else if (drop_lock && (realign_cnt != 8'hFF)) begin
      realign_cnt <= realign_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
// tb_tmds_decoder: scoreboard bench for tmds_decoder with short search and
// timeout limits. Stimulus pushes hand-computed expected words; a negedge
// monitor pops and compares whenever an aligned output word appears.
`timescale 1ns/1ps
module tb_tmds_decoder;

  localparam int CTRL_RUN      = 8;
  localparam int SEARCH_CYCLES = 64;
  localparam int LOCK_TIMEOUT  = 256;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] tmds_in = '0;
  logic [7:0] data_out;
  logic       data_en;
  logic       ctrl0_out;
  logic       ctrl1_out;
  logic       aligned;
  logic [3:0] phase;
`ifdef TMDS_DECODER_STATS_EN
  logic [7:0] realign_cnt;
`endif

  tmds_decoder #(
    .CTRL_RUN(CTRL_RUN),
    .SEARCH_CYCLES(SEARCH_CYCLES),
    .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .tmds_in(tmds_in),
    .data_out(data_out),
    .data_en(data_en),
    .ctrl0_out(ctrl0_out),
    .ctrl1_out(ctrl1_out),
    .aligned(aligned),
    .phase(phase)
`ifdef TMDS_DECODER_STATS_EN
    ,
    .realign_cnt(realign_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       de;
    logic [1:0] c;
    logic [7:0] d;
  } exp_t;

  exp_t       sb_q[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic       sb_on = 1'b0;
  logic [1:0] model_c = 2'b00;
  logic [1:0] mon_last_c = 2'b00;
  int         sh = 0;
  logic [9:0] tx_prev = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: an output word is a data word, or a control word whose bits changed
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && sb_on && aligned &&
        (data_en || ({ctrl1_out, ctrl0_out} != mon_last_c))) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL sb_unexpected: actual 0x%0h required none",
                 {data_en, ctrl1_out, ctrl0_out, data_out});
      end else begin
        e = sb_q.pop_front();
        check("sb_word", 32'({data_en, ctrl1_out, ctrl0_out, data_out}), 32'(e));
      end
    end
    mon_last_c = {ctrl1_out, ctrl0_out};
  end

  // Serialise the word stream delayed by sh bits, then one clock
  task automatic send_raw(input logic [9:0] wd);
    logic [19:0] comb;
    comb    = {wd, tx_prev};
    tmds_in = 10'(comb >> (10 - sh));
    tx_prev = wd;
    @(posedge clk);
    #1;
  endtask

  task automatic send_tok(input logic [9:0] wd, input logic [1:0] c);
    exp_t e;
    if (sb_on && (c != model_c)) begin
      e = {1'b0, c, 8'h00};
      sb_q.push_back(e);
    end
    model_c = c;
    send_raw(wd);
  endtask

  task automatic send_data(input logic [9:0] wd, input logic [7:0] dv);
    exp_t e;
    if (sb_on) begin
      e = {1'b1, model_c, dv};
      sb_q.push_back(e);
    end
    send_raw(wd);
  endtask

  task automatic drain_check();
    repeat (6) send_tok(10'h354, 2'b00);
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    sb_on = 1'b0;
  endtask

  // Asynchronous reset mid-clock, checked before the next edge
  task automatic do_reset();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_aligned", 32'(aligned), 32'd0);
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_de", 32'(data_en), 32'd0);
    check("rst_c0", 32'(ctrl0_out), 32'd0);
    check("rst_c1", 32'(ctrl1_out), 32'd0);
`ifdef TMDS_DECODER_STATS_EN
    check("rst_realign", 32'(realign_cnt), 32'd0);
`endif
    sb_on   = 1'b0;
    sb_q.delete();
    tmds_in = '0;
    tx_prev = '0;
    model_c = 2'b00;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    int k;

    // Phase-0 lock and data decode
    do_reset();
    sh = 0;
    for (int i = 1; i <= 16; i++) begin
      send_tok(10'h354, 2'b00);
      if (i == 10) check("lock0_early", 32'(aligned), 32'd0);
      if (i == 11) begin
        check("lock0_aligned", 32'(aligned), 32'd1);
        check("lock0_phase", 32'(phase), 32'd0);
      end
    end
    sb_on   = 1'b1;
    model_c = 2'b00;
    send_data(10'h100, 8'h00);
    send_data(10'h200, 8'hFF);
    send_data(10'h1AA, 8'hFE);
    send_data(10'h2F0, 8'hEF);
    send_data(10'h1F0, 8'h10);
    drain_check();

    // Stream delayed by three serial bits
    do_reset();
    sh = 3;
    k  = 0;
    while (!aligned && k < 400) begin
      send_tok(10'h354, 2'b00);
      k++;
      if (k == 100) check("slip_phase1", 32'(phase), 32'd1);
      if (k == 160) check("slip_phase2", 32'(phase), 32'd2);
    end
    check("lock3_aligned", 32'(aligned), 32'd1);
    check("lock3_phase", 32'(phase), 32'd3);
    repeat (4) send_tok(10'h354, 2'b00);
    sb_on   = 1'b1;
    model_c = 2'b00;
    send_data(10'h100, 8'h00);
    send_data(10'h200, 8'hFF);

    // Control token decode and control-bit hold across data words
    send_tok(10'h0AB, 2'b01);
    send_data(10'h100, 8'h00);
    send_tok(10'h154, 2'b10);
    send_tok(10'h154, 2'b10);
    send_tok(10'h2AB, 2'b11);
    send_data(10'h200, 8'hFF);
    send_tok(10'h354, 2'b00);
    drain_check();

    // Reset while locked with live data on the outputs
    repeat (6) send_data(10'h1AA, 8'hFE);
    check("pre_rst_data", 32'(data_out), 32'hFE);
    check("pre_rst_de", 32'(data_en), 32'd1);
    check("pre_rst_phase", 32'(phase), 32'd3);
    do_reset();

    // Lock at offset 9, then lose it through the data-only timeout
    sh = 9;
    k  = 0;
    while (!aligned && k < 1000) begin
      send_tok(10'h354, 2'b00);
      k++;
    end
    check("lock9_aligned", 32'(aligned), 32'd1);
    check("lock9_phase", 32'(phase), 32'd9);
    repeat (4) send_tok(10'h354, 2'b00);
    for (int i = 1; i <= 300; i++) begin
      send_data(10'h100, 8'h00);
      if (i == 258) check("to_still_locked", 32'(aligned), 32'd1);
      if (i == 259) begin
        check("to_dropped", 32'(aligned), 32'd0);
        check("to_phase_wrap", 32'(phase), 32'd0);
      end
    end
`ifdef TMDS_DECODER_STATS_EN
    check("realign_one", 32'(realign_cnt), 32'd1);
`endif

    // Run completing exactly on dwell end, then exactly on timeout
    do_reset();
    sh = 0;
    for (int e = 1; e <= 340; e++) begin
      if (e <= 53) send_raw(10'h000);
      else if (e <= 70 || e >= 319) send_tok(10'h354, 2'b00);
      else send_data(10'h100, 8'h00);
      if (e == 63) check("dwell_pre_lock", 32'(aligned), 32'd0);
      if (e == 64) begin
        check("dwell_lock", 32'(aligned), 32'd1);
        check("dwell_no_slip", 32'(phase), 32'd0);
      end
      if (e == 329) check("to_run_wins", 32'(aligned), 32'd1);
      if (e == 340) begin
        check("to_run_hold", 32'(aligned), 32'd1);
        check("to_run_phase", 32'(phase), 32'd0);
      end
    end
`ifdef TMDS_DECODER_STATS_EN
    check("realign_zero", 32'(realign_cnt), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
